hwpe_periph_master: RTL and testbench

HWPE_PERIPH_MASTER -- requirements
Module: hwpe_periph_master

---
 rtl/hwpe_periph_master.sv | 132 +++++++++++++
 tb/tb_hwpe_periph_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_periph_master.sv
// Single-outstanding peripheral bus master: command in, tagged periph request out, response back.
// Optional response timeout enabled by defining HWPE_PERIPH_MASTER_TIMEOUT_EN.
module hwpe_periph_master #(
    parameter int unsigned ID_WIDTH       = 10,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [31:0]         cmd_add_i,
    input  logic                cmd_wen_i,
    input  logic [3:0]          cmd_be_i,
    input  logic [31:0]         cmd_data_i,

    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_data_o,
    output logic                rsp_err_o,

    output logic                periph_req_o,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic                periph_gnt_i,
    input  logic                periph_r_valid_i,
    input  logic [31:0]         periph_r_data_i,
    input  logic [ID_WIDTH-1:0] periph_r_id_i,

    output logic                busy_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RSP} state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] tag_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [31:0]         add_q;
    logic                wen_q;
    logic [3:0]          be_q;
    logic [31:0]         data_q;
    logic [31:0]         rdata_q;
    logic                r_match;
    logic                timeout;
    logic                accept;

    assign accept  = (state_q == IDLE) && cmd_valid_i;
    assign r_match = periph_r_valid_i && (periph_r_id_i == id_q);

`ifdef HWPE_PERIPH_MASTER_TIMEOUT_EN
    logic [15:0] tcnt_q;
    logic        err_q;

    // Counts WAIT_R cycles; expiry on the last one lets a same-cycle match win.
    assign timeout   = (state_q == WAIT_R) && (tcnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign rsp_err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == WAIT_R && !r_match) tcnt_q <= tcnt_q + 16'd1;
            else                               tcnt_q <= '0;
            if (state_q == WAIT_R) begin
                if (r_match)      err_q <= 1'b0;
                else if (timeout) err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid_i)        state_d = REQ;
            REQ:     if (periph_gnt_i)       state_d = WAIT_R;
            WAIT_R:  if (r_match || timeout) state_d = RSP;
            RSP:     if (rsp_ready_i)        state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tag_q   <= '0;
            id_q    <= '0;
            add_q   <= '0;
            wen_q   <= 1'b0;
            be_q    <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                add_q  <= cmd_add_i;
                wen_q  <= cmd_wen_i;
                be_q   <= cmd_be_i;
                data_q <= cmd_data_i;
                id_q   <= tag_q;
                tag_q  <= tag_q + 1'b1;
            end
            if (state_q == WAIT_R) begin
                if (r_match)      rdata_q <= periph_r_data_i;
                else if (timeout) rdata_q <= 32'hDEADBEEF;
            end
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign periph_req_o  = (state_q == REQ);
    assign rsp_valid_o   = (state_q == RSP);
    assign busy_o        = (state_q != IDLE);
    assign periph_add_o  = add_q;
    assign periph_wen_o  = wen_q;
    assign periph_be_o   = be_q;
    assign periph_data_o = data_q;
    assign periph_id_o   = id_q;
    assign rsp_data_o    = rdata_q;

endmodule

// File: tb/tb_hwpe_periph_master.sv
// Self-checking bench for hwpe_periph_master: directed scenarios plus randomized transactions
// against a transaction-level model (tag sequence, expected response data/timing).
module tb_hwpe_periph_master;

    localparam int unsigned IDW = 10;
    localparam int unsigned TO  = 8;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           cmd_valid_i;
    logic           cmd_ready_o;
    logic [31:0]    cmd_add_i;
    logic           cmd_wen_i;
    logic [3:0]     cmd_be_i;
    logic [31:0]    cmd_data_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic [31:0]    rsp_data_o;
    logic           rsp_err_o;
    logic           periph_req_o;
    logic [31:0]    periph_add_o;
    logic           periph_wen_o;
    logic [3:0]     periph_be_o;
    logic [31:0]    periph_data_o;
    logic [IDW-1:0] periph_id_o;
    logic           periph_gnt_i;
    logic           periph_r_valid_i;
    logic [31:0]    periph_r_data_i;
    logic [IDW-1:0] periph_r_id_i;
    logic           busy_o;

    int          checks   = 0;
    int          failures = 0;
    int unsigned model_tag = 0;

    always #5 clk_i = ~clk_i;

    hwpe_periph_master #(.ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_add_i(cmd_add_i),
        .cmd_wen_i(cmd_wen_i), .cmd_be_i(cmd_be_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o),
        .periph_req_o(periph_req_o), .periph_add_o(periph_add_o), .periph_wen_o(periph_wen_o),
        .periph_be_o(periph_be_o), .periph_data_o(periph_data_o), .periph_id_o(periph_id_o),
        .periph_gnt_i(periph_gnt_i), .periph_r_valid_i(periph_r_valid_i),
        .periph_r_data_i(periph_r_data_i), .periph_r_id_i(periph_r_id_i),
        .busy_o(busy_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [IDW-1:0] exp_id();
        return IDW'(model_tag % (32'd1 << IDW));
    endfunction

    task automatic test_reset;
        rst_i = 1'b1;
        cmd_valid_i = 1'b1; cmd_add_i = $urandom; cmd_wen_i = 1'b1; cmd_be_i = 4'hF;
        cmd_data_i = $urandom; rsp_ready_i = 1'b0; periph_gnt_i = 1'b1;
        periph_r_valid_i = 1'b1; periph_r_data_i = $urandom; periph_r_id_i = '0;
        tick; tick;
        rst_i = 1'b0; cmd_valid_i = 1'b0; periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0;
        model_tag = 0;
        checks++;
        if ({periph_req_o, rsp_valid_o, rsp_err_o, busy_o, cmd_ready_o} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_ctrl: got req/rv/err/busy/rdy=%b want 00001",
                     {periph_req_o, rsp_valid_o, rsp_err_o, busy_o, cmd_ready_o});
        end
        checks++;
        if ({periph_add_o, periph_wen_o, periph_be_o, periph_data_o, periph_id_o, rsp_data_o} !== '0) begin
            failures++;
            $display("FAIL reset_data: got add=%h wen=%b be=%h data=%h id=%0d rdata=%h want all 0",
                     periph_add_o, periph_wen_o, periph_be_o, periph_data_o, periph_id_o, rsp_data_o);
        end
    endtask

    // One full transaction; the model supplies the expected tag, request fields and response.
    task automatic do_txn(input logic [31:0] add, input logic wen, input logic [3:0] be,
                          input logic [31:0] data, input int gnt_delay, input int rdelay,
                          input logic [31:0] rdata, input int rsp_stall, input int exp_cyc,
                          input string name);
        logic [IDW-1:0]    eid;
        logic [IDW+68:0]   exp_req;
        int                cyc;
        eid     = exp_id();
        exp_req = {add, wen, be, data, eid};
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s cmd_ready_idle: got %b want 1", name, cmd_ready_o);
        end
        cmd_valid_i = 1'b1; cmd_add_i = add; cmd_wen_i = wen; cmd_be_i = be; cmd_data_i = data;
        cyc = 0;
        tick; cyc++;
        cmd_valid_i = 1'b0; cmd_add_i = $urandom; cmd_wen_i = ~wen; cmd_be_i = ~be; cmd_data_i = $urandom;
        for (int i = 0; i <= gnt_delay; i++) begin
            checks++;
            if ({periph_req_o, periph_add_o, periph_wen_o, periph_be_o, periph_data_o, periph_id_o}
                !== {1'b1, exp_req}) begin
                failures++;
                $display("FAIL %s req_fields[%0d]: got req=%b add=%h wen=%b be=%h data=%h id=%0d want req=1 add=%h wen=%b be=%h data=%h id=%0d",
                         name, i, periph_req_o, periph_add_o, periph_wen_o, periph_be_o, periph_data_o,
                         periph_id_o, add, wen, be, data, eid);
            end
            periph_gnt_i     = (i == gnt_delay);
            periph_r_valid_i = (i != gnt_delay) && ($urandom_range(0, 1) == 1);
            periph_r_id_i    = eid;
            periph_r_data_i  = $urandom;
            tick; cyc++;
        end
        periph_gnt_i = 1'b0;
        for (int i = 0; i < rdelay; i++) begin
            checks++;
            if ({periph_req_o, rsp_valid_o, busy_o} !== 3'b001) begin
                failures++;
                $display("FAIL %s wait_r[%0d]: got req/rv/busy=%b want 001", name, i,
                         {periph_req_o, rsp_valid_o, busy_o});
            end
            periph_r_valid_i = (i == 0) || ($urandom_range(0, 1) == 1);
            periph_r_id_i    = eid + 1'b1;
            periph_r_data_i  = $urandom;
            tick; cyc++;
        end
        periph_r_valid_i = 1'b1; periph_r_id_i = eid; periph_r_data_i = rdata;
        tick; cyc++;
        periph_r_valid_i = 1'b0; periph_r_data_i = $urandom;
        checks++;
        if ({rsp_valid_o, rsp_data_o, rsp_err_o} !== {1'b1, rdata, 1'b0}) begin
            failures++;
            $display("FAIL %s rsp: got valid=%b data=%h err=%b want valid=1 data=%h err=0",
                     name, rsp_valid_o, rsp_data_o, rsp_err_o, rdata);
        end
        if (exp_cyc >= 0) begin
            checks++;
            if (cyc != exp_cyc) begin
                failures++;
                $display("FAIL %s rsp_cycle: got %0d want %0d", name, cyc, exp_cyc);
            end
        end
        rsp_ready_i = 1'b0;
        for (int i = 0; i < rsp_stall; i++) begin
            cmd_valid_i = 1'b1;
            tick;
            checks++;
            if ({rsp_valid_o, rsp_data_o, rsp_err_o, cmd_ready_o} !== {1'b1, rdata, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL %s rsp_hold[%0d]: got valid=%b data=%h err=%b rdy=%b want 1 %h 0 0",
                         name, i, rsp_valid_o, rsp_data_o, rsp_err_o, cmd_ready_o, rdata);
            end
        end
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0; cmd_valid_i = 1'b0;
        checks++;
        if ({rsp_valid_o, cmd_ready_o, busy_o} !== 3'b010) begin
            failures++;
            $display("FAIL %s after_rsp: got rv/rdy/busy=%b want 010", name,
                     {rsp_valid_o, cmd_ready_o, busy_o});
        end
        model_tag++;
    endtask

    task automatic test_write_basic;
        do_txn(32'h100, 1'b0, 4'hF, 32'hCAFE0001, 0, 1, 32'hA5A5_0F0F, 0, 4, "write_basic");
    endtask

    task automatic test_read_stall;
        do_txn($urandom, 1'b1, 4'h3, $urandom, 5, 0, 32'h12345678, 2, -1, "read_gnt_stall");
    endtask

    task automatic test_wrong_id;
        do_txn($urandom, 1'b1, 4'hC, $urandom, 0, 3, 32'h0BADF00D, 1, -1, "wrong_id");
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            do_txn($urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                   $urandom_range(0, 4), $urandom_range(0, TO - 1), $urandom,
                   $urandom_range(0, 3), -1, "random");
        end
    endtask

    task automatic test_match_at_expiry;
        do_txn($urandom, 1'b1, 4'hF, $urandom, 1, TO - 1, 32'h600D_600D, 0, -1, "match_at_expiry");
    endtask

    task automatic test_timeout;
        cmd_valid_i = 1'b1; cmd_add_i = $urandom; cmd_wen_i = 1'b1; cmd_be_i = 4'hF;
        tick;
        cmd_valid_i = 1'b0; periph_gnt_i = 1'b1;
        tick;
        periph_gnt_i = 1'b0;
        model_tag++;
`ifdef HWPE_PERIPH_MASTER_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            checks++;
            if ({rsp_valid_o, busy_o} !== 2'b01) begin
                failures++;
                $display("FAIL timeout_wait[%0d]: got rv/busy=%b want 01", i, {rsp_valid_o, busy_o});
            end
            tick;
        end
        checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_data_o} !== {1'b1, 1'b1, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL timeout_rsp: got valid=%b err=%b data=%h want 1 1 deadbeef",
                     rsp_valid_o, rsp_err_o, rsp_data_o);
        end
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
        checks++;
        if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL timeout_done: got rv/rdy=%b want 01", {rsp_valid_o, cmd_ready_o});
        end
`else
        for (int i = 0; i < 5 * TO; i++) begin
            checks++;
            if ({rsp_valid_o, rsp_err_o, busy_o} !== 3'b001) begin
                failures++;
                $display("FAIL no_timeout_wait[%0d]: got rv/err/busy=%b want 001", i,
                         {rsp_valid_o, rsp_err_o, busy_o});
            end
            tick;
        end
        test_reset;
`endif
    endtask

    task automatic test_reset_mid;
        logic [IDW-1:0] old_id;
        old_id = exp_id();
        cmd_valid_i = 1'b1; cmd_add_i = $urandom;
        tick;
        cmd_valid_i = 1'b0; periph_gnt_i = 1'b1;
        tick;
        periph_gnt_i = 1'b0;
        tick;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        model_tag = 0;
        periph_r_valid_i = 1'b1; periph_r_id_i = old_id; periph_r_data_i = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick;
            periph_r_valid_i = 1'b0;
            checks++;
            if ({rsp_valid_o, busy_o, cmd_ready_o} !== 3'b001) begin
                failures++;
                $display("FAIL reset_mid[%0d]: got rv/busy/rdy=%b want 001", i,
                         {rsp_valid_o, busy_o, cmd_ready_o});
            end
        end
        do_txn($urandom, 1'b0, 4'h1, $urandom, 0, 0, $urandom, 0, -1, "after_reset_mid");
    endtask

    task automatic test_back_to_back;
        test_reset;
        for (int n = 0; n < (1 << IDW) + 1; n++) begin
            do_txn($urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                   0, 0, $urandom, 0, -1, "back_to_back");
        end
        checks++;
        if (exp_id() !== IDW'(1)) begin
            failures++;
            $display("FAIL b2b_model_tag: got %0d want 1", exp_id());
        end
    endtask

    initial begin
        test_reset;
        test_write_basic;
        test_read_stall;
        test_wrong_id;
        test_random;
        test_match_at_expiry;
        test_timeout;
        test_random;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
